mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the pipelined MIPS core's two memory ports: instruction fetch and data access. One single-port synchronous RAM serves both ports. A round-robin arbiter and a req/valid handshake let the core stall either stage until its access completes. The block sits directly under the SoC top, opposite the core's fetch and memory-stage ports.

Parameters:
ADDR_W, 10, word-index width; RAM holds 2**ADDR_W 32-bit words
INIT_ZERO, 1, when 1 the simulation model zero-fills the RAM at time 0 (not at reset)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
ireq  in  1  fetch request; held high until ivalid
iaddr  in  32  fetch byte address (pcF)
irdata  out  32  fetched instruction (instrF)
ivalid  out  1  fetch response, one-cycle pulse
dreq  in  1  data request; held high until dvalid
dwe  in  1  1 = write, 0 = read (memwriteM)
dbe  in  4  byte enables for writes; bit i gates byte i (bits [8i+7:8i])
daddr  in  32  data byte address (aluoutM)
dwdata  in  32  write data (writedataM)
drdata  out  32  read data (readdataM)
dvalid  out  1  data response, one-cycle pulse
stallF  out  1  ireq & ~ivalid
stallM  out  1  dreq & ~dvalid
misalign  out  1  sticky; set when a granted access has addr[1:0] != 0

Behaviour:
- Reset: state=IDLE, ivalid=0, dvalid=0, irdata=0, drdata=0, misalign=0, last_grant=DATA (so instruction fetch wins the first contention). RAM contents are not reset.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias and wrap. addr[1:0] is ignored for the access; a nonzero value sets misalign.
- FSM states: IDLE, I_RESP, D_RESP.
- IDLE, grant selection:
  - Only dreq high: grant DATA.
  - Only ireq high: grant INSTR.
  - Both high: grant the port opposite last_grant.
  - Neither high: stay in IDLE.
- IDLE, on the grant edge: issue the RAM access, update last_grant, move to I_RESP or D_RESP.
- D_RESP: dvalid=1 for exactly one cycle.
  - Read: drdata = RAM word.
  - Write: the RAM is updated on the grant edge, and only the bytes with dbe=1 change. drdata = the pre-write word (read-before-write).
  - dbe is ignored for reads.
  - Next state is IDLE.
- I_RESP: ivalid=1 for exactly one cycle, irdata = RAM word. Next state is IDLE.
- Latency and throughput:
  - Request seen in IDLE at cycle t; response valid in cycle t+1.
  - Each port gets at most one access per 2 cycles.
  - If both ports are pending, the aggregate is one access per 2 cycles, alternating between ports.
- irdata and drdata hold their last value when their valid is low.
- Dropping a req while it is pending is illegal. If it happens, the response is still produced and the data is discarded by the core.
- A req seen high in the RESP cycle is treated as the same request. No new access is granted until the FSM is back in IDLE.
- Reset mid-operation: rst high on the grant edge suppresses the write. rst high during RESP forces IDLE and clears the valids on the next edge.
- Simultaneous write and fetch to the same word: the order follows the grant. A fetch granted after the write returns the new data.
- stallF and stallM are combinational from req and valid.

Test Plan:
1. Reset, then ireq=1, iaddr=0x0000_0040 with RAM[16]=0x2008_0005 -> ivalid=1 in cycle t+1, irdata=0x2008_0005, stallF=1 in cycle t and 0 in t+1.
2. dreq=1, dwe=1, dbe=0xF, daddr=0x100, dwdata=0xDEAD_BEEF, then a read of 0x100 -> dvalid pulses twice; the second drdata=0xDEAD_BEEF.
3. Byte write dbe=0x2, dwdata=0x0000_AB00 over 0x1122_3344 at 0x104 -> the following read returns 0x1122_AB44.
4. ireq and dreq held together for 8 cycles from reset -> grants alternate INSTR, DATA, INSTR, DATA, and the valids alternate every other cycle.
5. Read of daddr=0x102 -> misalign=1 and stays 1; data returned is the word at 0x100; rst clears misalign.
6. rst asserted on the grant edge of a write of 0x5555_5555 to 0x200 holding 0x0 -> no dvalid; a later read of 0x200 returns 0x0; state is IDLE.

Source files
------------

// File: rtl/mem_responder_if.sv
// Core-facing bundle for the shared instruction/data memory responder.
// The core drives the requests; the responder returns data, valids, stalls and misalign.
interface mem_responder_if;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        ivalid;
  logic        dreq;
  logic        dwe;
  logic [3:0]  dbe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dvalid;
  logic        stallF;
  logic        stallM;
  logic        misalign;

  modport master (
    output ireq, iaddr, dreq, dwe, dbe, daddr, dwdata,
    input  irdata, ivalid, drdata, dvalid, stallF, stallM, misalign
  );

  modport slave (
    input  ireq, iaddr, dreq, dwe, dbe, daddr, dwdata,
    output irdata, ivalid, drdata, dvalid, stallF, stallM, misalign
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port RAM shared by the fetch and data ports of the MIPS core.
// A round-robin arbiter grants one access per IDLE cycle; each response is a one-cycle valid pulse.
module mem_responder #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_RESP = 2'd1,
    D_RESP = 2'd2
  } state_t;

  localparam int Depth = 1 << ADDR_W;

  state_t      state_q, state_d;
  logic        lastData_q, lastData_d;
  logic        ivalid_q, ivalid_d;
  logic        dvalid_q, dvalid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;

  logic [31:0] mem [Depth];

  logic              grantI;
  logic              grantD;
  logic [ADDR_W-1:0] ramIdx;
  logic [1:0]        ramOff;
  logic              ramWe;
  logic [31:0]       ramWord;
  logic [31:0]       ramWdata;

  // The RAM has no reset; INIT_ZERO only describes its time-zero contents in simulation.
  logic unusedBits;
  assign unusedBits = ^{bus.iaddr[31:ADDR_W+2], bus.daddr[31:ADDR_W+2], INIT_ZERO};

  // Ties go to the port that was not served last.
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (state_q == IDLE) begin
      if (bus.ireq && bus.dreq) begin
        grantI = lastData_q;
        grantD = ~lastData_q;
      end else begin
        grantI = bus.ireq;
        grantD = bus.dreq;
      end
    end
  end

  always_comb begin
    ramIdx  = grantD ? bus.daddr[ADDR_W+1:2] : bus.iaddr[ADDR_W+1:2];
    ramOff  = grantD ? bus.daddr[1:0] : bus.iaddr[1:0];
    ramWord = mem[ramIdx];
    ramWe   = grantD & bus.dwe & ~rst;
    for (int b = 0; b < 4; b++) begin
      ramWdata[8*b +: 8] = bus.dbe[b] ? bus.dwdata[8*b +: 8] : ramWord[8*b +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    lastData_d = lastData_q;
    ivalid_d   = 1'b0;
    dvalid_d   = 1'b0;
    misalign_d = misalign_q;
    irdata_d   = irdata_q;
    drdata_d   = drdata_q;
    case (state_q)
      IDLE: begin
        if (grantI) begin
          state_d    = I_RESP;
          lastData_d = 1'b0;
          ivalid_d   = 1'b1;
          irdata_d   = ramWord;
          if (ramOff != 2'b00) misalign_d = 1'b1;
        end else if (grantD) begin
          state_d    = D_RESP;
          lastData_d = 1'b1;
          dvalid_d   = 1'b1;
          drdata_d   = ramWord;
          if (ramOff != 2'b00) misalign_d = 1'b1;
        end
      end
      I_RESP:  state_d = IDLE;
      D_RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lastData_q <= 1'b1;
      ivalid_q   <= 1'b0;
      dvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      lastData_q <= lastData_d;
      ivalid_q   <= ivalid_d;
      dvalid_q   <= dvalid_d;
      misalign_q <= misalign_d;
      irdata_q   <= irdata_d;
      drdata_q   <= drdata_d;
    end
  end

  // The response register captures the old word, giving read-before-write on a write grant.
  always_ff @(posedge clk) begin
    if (ramWe) mem[ramIdx] <= ramWdata;
  end

  assign bus.irdata   = irdata_q;
  assign bus.ivalid   = ivalid_q;
  assign bus.drdata   = drdata_q;
  assign bus.dvalid   = dvalid_q;
  assign bus.misalign = misalign_q;
  assign bus.stallF   = bus.ireq & ~ivalid_q;
  assign bus.stallM   = bus.dreq & ~dvalid_q;

  aValidExclusive: assert property (@(posedge clk) !(ivalid_q && dvalid_q));
  aIvalidPulse:    assert property (@(posedge clk) disable iff (rst) ivalid_q |=> !ivalid_q);
  aDvalidPulse:    assert property (@(posedge clk) disable iff (rst) dvalid_q |=> !dvalid_q);
  aIdleNoValid:    assert property (@(posedge clk) (state_q == IDLE) |-> !(ivalid_q || dvalid_q));

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written corner sequences,
// then random traffic checked against a word-array reference model.
module tb_mem_responder;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus ();

  mem_responder #(.ADDR_W(AW), .INIT_ZERO(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory words, which words hold known data, arbitration history, sticky flag.
  logic [31:0] refMem   [WORDS];
  bit          refKnown [WORDS];
  bit          refLastData = 1'b1;
  bit          refMis      = 1'b0;

  typedef struct {
    bit          doI;
    logic [31:0] ia;
    bit          doD;
    bit          we;
    logic [3:0]  be;
    logic [31:0] da;
    logic [31:0] wd;
    bit          chkI;
    logic [31:0] expI;
    bit          chkD;
    logic [31:0] expD;
    bit          expMis;
  } vec_t;

  vec_t vecs [13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int wordOf(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic void refAccess(input bit isData, input logic [31:0] a, input bit we,
                                    input logic [3:0] be, input logic [31:0] wd,
                                    output logic [31:0] rd, output bit known);
    int w;
    w     = wordOf(a);
    rd    = refMem[w];
    known = refKnown[w];
    if (a[1:0] != 2'b00) refMis = 1'b1;
    refLastData = isData;
    if (isData && we) begin
      for (int b = 0; b < 4; b++) if (be[b]) refMem[w][8*b +: 8] = wd[8*b +: 8];
      if (be == 4'hF) refKnown[w] = 1'b1;
    end
  endfunction

  // Issues one request (or one per port), checks every cycle until all responses arrive.
  task automatic applyStimulus(input bit doI, input logic [31:0] ia, input bit doD, input bit we,
                               input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd,
                               input bit useTab, input bit chkI, input logic [31:0] tabI,
                               input bit chkD, input logic [31:0] tabD, input bit tabMis,
                               input string tag);
    bit          twoAcc, dataFirst, firstKn, secondKn, mis1, mis2;
    bit          haveI, haveD, iPend, dPend, expIv, expDv, expMis;
    logic [31:0] firstRd, secondRd, expIdata, expDdata;
    int          nCyc;
    secondRd  = '0;
    secondKn  = 1'b0;
    twoAcc    = doI && doD;
    dataFirst = twoAcc ? !refLastData : doD;
    if (dataFirst) refAccess(1'b1, da, we, be, wd, firstRd, firstKn);
    else           refAccess(1'b0, ia, 1'b0, 4'h0, 32'h0, firstRd, firstKn);
    mis1 = refMis;
    if (twoAcc) begin
      if (dataFirst) refAccess(1'b0, ia, 1'b0, 4'h0, 32'h0, secondRd, secondKn);
      else           refAccess(1'b1, da, we, be, wd, secondRd, secondKn);
    end
    mis2 = refMis;
    if (dataFirst) begin
      expDdata = firstRd;  haveD = firstKn;  expIdata = secondRd; haveI = secondKn;
    end else begin
      expIdata = firstRd;  haveI = firstKn;  expDdata = secondRd; haveD = secondKn;
    end
    if (useTab) begin
      expIdata = tabI; haveI = chkI; expDdata = tabD; haveD = chkD;
    end

    @(negedge clk);
    bus.ireq = doI; bus.iaddr = ia;
    bus.dreq = doD; bus.dwe = we; bus.dbe = be; bus.daddr = da; bus.dwdata = wd;
    iPend = doI; dPend = doD;
    #1;
    checkOutput({tag, " stallF before grant"}, 32'(bus.stallF), 32'(doI));
    checkOutput({tag, " stallM before grant"}, 32'(bus.stallM), 32'(doD));

    nCyc = twoAcc ? 3 : 1;
    for (int c = 1; c <= nCyc; c++) begin
      @(negedge clk);
      expIv  = doI && ((!dataFirst && c == 1) || (dataFirst && c == 3));
      expDv  = doD && ((dataFirst && c == 1) || (!dataFirst && c == 3));
      expMis = useTab ? tabMis : ((c == 3) ? mis2 : mis1);
      checkOutput({tag, " ivalid"},   32'(bus.ivalid),   32'(expIv));
      checkOutput({tag, " dvalid"},   32'(bus.dvalid),   32'(expDv));
      checkOutput({tag, " stallF"},   32'(bus.stallF),   32'(iPend & ~expIv));
      checkOutput({tag, " stallM"},   32'(bus.stallM),   32'(dPend & ~expDv));
      checkOutput({tag, " misalign"}, 32'(bus.misalign), 32'(expMis));
      if (expIv) begin
        if (haveI) checkOutput({tag, " irdata"}, bus.irdata, expIdata);
        bus.ireq = 1'b0; iPend = 1'b0;
      end
      if (expDv) begin
        if (haveD) checkOutput({tag, " drdata"}, bus.drdata, expDdata);
        bus.dreq = 1'b0; dPend = 1'b0;
      end
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1; bus.ireq = 1'b0; bus.dreq = 1'b0;
    @(negedge clk);
    checkOutput({tag, " ivalid"},   32'(bus.ivalid),   32'h0);
    checkOutput({tag, " dvalid"},   32'(bus.dvalid),   32'h0);
    checkOutput({tag, " irdata"},   bus.irdata,        32'h0);
    checkOutput({tag, " drdata"},   bus.drdata,        32'h0);
    checkOutput({tag, " misalign"}, 32'(bus.misalign), 32'h0);
    rst = 1'b0;
    refMis = 1'b0; refLastData = 1'b1;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_F000;
    a[AW+1:2] = AW'($urandom_range(0, 31));
    a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.ireq = 1'b0; bus.iaddr = '0;
    bus.dreq = 1'b0; bus.dwe = 1'b0; bus.dbe = '0; bus.daddr = '0; bus.dwdata = '0;

    //          doI  ia            doD  we  be    da            wd            chkI expI          chkD expD          mis
    vecs[0]  = '{0, 32'h0,        1,  1, 4'hF, 32'h0000_0040, 32'h2008_0005, 0, 32'h0,         0, 32'h0,         0};
    vecs[1]  = '{1, 32'h0000_0040, 0, 0, 4'h0, 32'h0,         32'h0,         1, 32'h2008_0005, 0, 32'h0,         0};
    vecs[2]  = '{0, 32'h0,        1,  1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,         0};
    vecs[3]  = '{0, 32'h0,        1,  0, 4'hF, 32'h0000_0100, 32'h0,         0, 32'h0,         1, 32'hDEAD_BEEF, 0};
    vecs[4]  = '{0, 32'h0,        1,  1, 4'hF, 32'h0000_0104, 32'h1122_3344, 0, 32'h0,         0, 32'h0,         0};
    vecs[5]  = '{0, 32'h0,        1,  1, 4'h2, 32'h0000_0104, 32'h0000_AB00, 0, 32'h0,         1, 32'h1122_3344, 0};
    vecs[6]  = '{0, 32'h0,        1,  0, 4'hF, 32'h0000_0104, 32'h0,         0, 32'h0,         1, 32'h1122_AB44, 0};
    vecs[7]  = '{0, 32'h0,        1,  1, 4'hF, 32'h0000_0200, 32'h0,         0, 32'h0,         0, 32'h0,         0};
    vecs[8]  = '{0, 32'h0,        1,  0, 4'hF, 32'h0000_0200, 32'h0,         0, 32'h0,         1, 32'h0,         0};
    vecs[9]  = '{0, 32'h0,        1,  0, 4'hF, 32'h0000_0102, 32'h0,         0, 32'h0,         1, 32'hDEAD_BEEF, 1};
    vecs[10] = '{1, 32'h0000_1040, 0, 0, 4'h0, 32'h0,         32'h0,         1, 32'h2008_0005, 0, 32'h0,         1};
    vecs[11] = '{0, 32'h0,        1,  0, 4'h0, 32'h0000_0104, 32'hFFFF_FFFF, 0, 32'h0,         1, 32'h1122_AB44, 1};
    vecs[12] = '{1, 32'h0000_0042, 0, 0, 4'h0, 32'h0,         32'h0,         1, 32'h2008_0005, 0, 32'h0,         1};

    doReset("reset");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].doI, vecs[i].ia, vecs[i].doD, vecs[i].we, vecs[i].be, vecs[i].da,
                    vecs[i].wd, 1'b1, vecs[i].chkI, vecs[i].expI, vecs[i].chkD, vecs[i].expD,
                    vecs[i].expMis, $sformatf("vec%0d", i));
    end

    doReset("reset clears misalign");

    // Reset while a fetch response is on the bus.
    @(negedge clk);
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0040;
    @(negedge clk);
    checkOutput("rstResp ivalid", 32'(bus.ivalid), 32'h1);
    checkOutput("rstResp irdata", bus.irdata, 32'h2008_0005);
    bus.ireq = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstResp ivalid cleared", 32'(bus.ivalid), 32'h0);
    checkOutput("rstResp irdata cleared", bus.irdata, 32'h0);
    rst = 1'b0;
    refMis = 1'b0; refLastData = 1'b1;

    // Both ports held for 8 cycles: INSTR, DATA, INSTR, DATA on alternate cycles.
    @(negedge clk);
    bus.ireq = 1'b1; bus.iaddr = 32'h0000_0040;
    bus.dreq = 1'b1; bus.dwe = 1'b0; bus.dbe = 4'hF; bus.daddr = 32'h0000_0104;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("contend c%0d ivalid", c), 32'(bus.ivalid), 32'((c % 4) == 1));
      checkOutput($sformatf("contend c%0d dvalid", c), 32'(bus.dvalid), 32'((c % 4) == 3));
      checkOutput($sformatf("contend c%0d stallF", c), 32'(bus.stallF), 32'((c % 4) != 1));
      checkOutput($sformatf("contend c%0d stallM", c), 32'(bus.stallM), 32'((c % 4) != 3));
      checkOutput($sformatf("contend c%0d irdata", c), bus.irdata, 32'h2008_0005);
      checkOutput($sformatf("contend c%0d drdata", c), bus.drdata, (c < 3) ? 32'h0 : 32'h1122_AB44);
    end
    bus.ireq = 1'b0; bus.dreq = 1'b0;
    refLastData = 1'b1;

    // Write and fetch of the same word; the write wins the grant so the fetch sees new data.
    applyStimulus(0, 32'h0, 1, 1, 4'hF, 32'h0000_0080, 32'hA5A5_0001, 0, 0, 32'h0, 0, 32'h0, 0, "collide prep");
    applyStimulus(1, 32'h0000_0080, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, "collide fetch");
    applyStimulus(1, 32'h0000_0080, 1, 1, 4'hF, 32'h0000_0080, 32'h0BAD_F00D,
                  1, 1, 32'h0BAD_F00D, 1, 32'hA5A5_0001, 0, "collide");

    // Reset on the grant edge of a write must suppress it.
    @(negedge clk);
    bus.dreq = 1'b1; bus.dwe = 1'b1; bus.dbe = 4'hF; bus.daddr = 32'h0000_0200;
    bus.dwdata = 32'h5555_5555; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstGrant dvalid", 32'(bus.dvalid), 32'h0);
    rst = 1'b0; bus.dreq = 1'b0; bus.dwe = 1'b0;
    @(negedge clk);
    checkOutput("rstGrant dvalid after", 32'(bus.dvalid), 32'h0);
    checkOutput("rstGrant stallM", 32'(bus.stallM), 32'h0);
    refMis = 1'b0; refLastData = 1'b1;
    applyStimulus(0, 32'h0, 1, 0, 4'hF, 32'h0000_0200, 32'h0, 1, 0, 32'h0, 1, 32'h0, 0, "rstGrant readback");

    // Random traffic over 32 words with aliased upper bits and occasional misaligned offsets.
    for (int w = 0; w < 32; w++) begin
      applyStimulus(0, 32'h0, 1, 1, 4'hF, 32'(w << 2), $urandom, 0, 0, 32'h0, 0, 32'h0, 0,
                    $sformatf("init w%0d", w));
    end
    for (int n = 0; n < 150; n++) begin
      int mode;
      mode = $urandom_range(0, 2);
      applyStimulus(mode != 1, randAddr(), mode != 0, 1'($urandom_range(0, 1)), 4'($urandom),
                    randAddr(), $urandom, 0, 0, 32'h0, 0, 32'h0, 0, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
